// File: rtl/bf16_subtractor_pipe.sv
// bf16_subtractor_pipe: three-stage pipelined bf16 z = a - b with valid/ready flow control and tag sideband.
// Define BF16_SUB_DAZ_EN to treat subnormal inputs and results as signed zero.
module bf16_subtractor_pipe #(
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [15:0]      a,
   input  logic [15:0]      b,
   input  logic [TAG_W-1:0] tag_in,
   input  logic             in_vld,
   output logic             in_rdy,
   output logic [15:0]      z,
   output logic [TAG_W-1:0] tag_out,
   output logic             z_vld,
   input  logic             z_rdy
);
   logic stall;
   logic [7:0] ea, eb, ea_eff, eb_eff, d;
   logic sa, sb, nan_a, nan_b, inf_a, inf_b, zero_a, zero_b, a_big;
   logic [10:0] ma, mb, m_small, m_al;
   logic sp1;
   logic [15:0] spv1;
   logic s1_vld, s2_vld, s1_sp, s2_sp, s1_sa, s1_sb, s2_s;
   logic [TAG_W-1:0] s1_tag, s2_tag;
   logic [15:0] s1_spv, s2_spv;
   logic [7:0] s1_e, s2_e;
   logic [10:0] s1_ma, s1_mb;
   logic [11:0] s2_m, sum;
   logic eff_sub, a_ge, sum_s;
   logic [3:0] lz;
   logic [7:0] sh;
   logic [10:0] m11;
   logic [8:0] e9;
   logic inc;
   logic [15:0] rnd, res;

   assign stall = z_vld && !z_rdy;
   assign in_rdy = !stall;

   // b is negated up front so the rest of the datapath is a plain signed add
   always_comb begin
      ea = a[14:7];
      eb = b[14:7];
      sa = a[15];
      sb = ~b[15];
      nan_a = &ea && |a[6:0];
      nan_b = &eb && |b[6:0];
      inf_a = &ea && ~|a[6:0];
      inf_b = &eb && ~|b[6:0];
`ifdef BF16_SUB_DAZ_EN
      zero_a = ea == 8'd0;
      zero_b = eb == 8'd0;
`else
      zero_a = ea == 8'd0 && a[6:0] == 7'd0;
      zero_b = eb == 8'd0 && b[6:0] == 7'd0;
`endif
      ma = zero_a ? 11'd0 : {ea != 8'd0, a[6:0], 3'b000};
      mb = zero_b ? 11'd0 : {eb != 8'd0, b[6:0], 3'b000};
      ea_eff = ea == 8'd0 ? 8'd1 : ea;
      eb_eff = eb == 8'd0 ? 8'd1 : eb;
      a_big = ea_eff >= eb_eff;
      d = a_big ? ea_eff - eb_eff : eb_eff - ea_eff;
      m_small = a_big ? mb : ma;
      m_al = d >= 8'd11 ? {10'd0, |m_small} : (m_small >> d) | {10'd0, |(m_small & ~(11'h7FF << d))};
      sp1 = nan_a || nan_b || inf_a || inf_b || (zero_a && zero_b);
      spv1 = (nan_a || nan_b || (inf_a && inf_b && sa != sb)) ? 16'h7FC0 :
             inf_a ? a : inf_b ? {sb, b[14:0]} : {sa && sb, 15'd0};
   end

   assign eff_sub = s1_sa != s1_sb;
   assign a_ge = s1_ma >= s1_mb;
   assign sum = !eff_sub ? {1'b0, s1_ma} + {1'b0, s1_mb} :
                a_ge ? {1'b0, s1_ma - s1_mb} : {1'b0, s1_mb - s1_ma};
   assign sum_s = !eff_sub ? s1_sa : s1_ma == s1_mb ? 1'b0 : a_ge ? s1_sa : s1_sb;

   // left shift is capped so the exponent never drops below 1; a missing hidden bit then means subnormal
   always_comb begin
      lz = 4'd11;
      for (int i = 0; i < 11; i++) lz = s2_m[i] ? 4'(10 - i) : lz;
      sh = {4'd0, lz} < s2_e - 8'd1 ? {4'd0, lz} : s2_e - 8'd1;
      m11 = s2_m[11] ? {s2_m[11:2], |s2_m[1:0]} : s2_m[10:0] << sh;
      e9 = s2_m[11] ? {1'b0, s2_e} + 9'd1 : m11[10] ? {1'b0, s2_e - sh} : 9'd0;
      inc = m11[2] && (m11[1] || m11[0] || m11[3]);
      rnd = {e9, m11[9:3]} + {15'd0, inc};
      res = rnd[15:7] >= 9'd255 ? {s2_s, 15'h7F80} : {s2_s, rnd[14:0]};
`ifdef BF16_SUB_DAZ_EN
      res = rnd[15:7] == 9'd0 ? {s2_s, 15'd0} : res;
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_vld <= 1'b0;
         s2_vld <= 1'b0;
         z_vld <= 1'b0;
         z <= 16'd0;
         tag_out <= '0;
      end else if (!stall) begin
         s1_vld <= in_vld;
         s2_vld <= s1_vld;
         z_vld <= s2_vld;
         if (s2_vld) begin
            z <= s2_sp ? s2_spv : res;
            tag_out <= s2_tag;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!stall) begin
         s1_tag <= tag_in;
         s1_sp <= sp1;
         s1_spv <= spv1;
         s1_e <= a_big ? ea_eff : eb_eff;
         s1_sa <= sa;
         s1_sb <= sb;
         s1_ma <= a_big ? ma : m_al;
         s1_mb <= a_big ? m_al : mb;
         s2_tag <= s1_tag;
         s2_sp <= s1_sp;
         s2_spv <= s1_spv;
         s2_e <= s1_e;
         s2_s <= sum_s;
         s2_m <= sum;
      end
   end
endmodule
